branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit_pkg.sv | 34 +++
 rtl/branch_resolve_unit_sat_counter.sv | 28 ++
 rtl/branch_resolve_unit.sv | 139 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared core package: recovery FSM encoding and control-flow class constants.
// Contents:
//   brs_state_e  - branch-resolve recovery FSM states (RUN / RECOVER)
//   cf_class_e   - E-stage control-flow class of the resolving instruction
//   cf_class()   - collapse the decoder's one-hot class flags into cf_class_e
package branch_resolve_unit_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } brs_state_e;

    typedef enum logic [1:0] {
        CF_NONE   = 2'd0,
        CF_BRANCH = 2'd1,
        CF_JAL    = 2'd2,
        CF_JALR   = 2'd3
    } cf_class_e;

    // Decoder guarantees at most one flag is set; fixed priority keeps it total.
    function automatic cf_class_e cf_class(input logic is_branch,
                                           input logic is_jal,
                                           input logic is_jalr);
        if (is_branch) begin
            return CF_BRANCH;
        end else if (is_jal) begin
            return CF_JAL;
        end else if (is_jalr) begin
            return CF_JALR;
        end
        return CF_NONE;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter used for the branch statistics.
// Ports:
//   clk, reset (async, active-high)
//   inc   - add one this cycle (ignored once the count is all-ones)
//   clear - synchronous clear to zero, wins over inc
//   count - current value
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    // Hold at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries fetch-stage predictions through D and E,
// compares them with the E-stage outcome, requests redirect/flush on a
// misprediction, trains the predictor and keeps resolve statistics.
// Ports:
//   clk, reset            - clock, async active-high reset
//   stall_d               - hazard unit holds IF/ID; E receives a bubble
//   pred_taken_f/target_f - fetch-stage prediction, valid_f marks a real slot
//   is_branch/jal/jalr_e  - E-stage control-flow class
//   cond_true_e, target_e, pc_plus4_e - E-stage resolution inputs
//   mispredict, redirect_pc, taken_e, update_en, flush_d, flush_e - resolve outputs
//   br_count, mp_count    - saturating resolve / mispredict counts
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_d,
    input  logic             pred_taken_f,
    input  logic [XLEN-1:0]  pred_target_f,
    input  logic             valid_f,
    input  logic             is_branch_e,
    input  logic             is_jal_e,
    input  logic             is_jalr_e,
    input  logic             cond_true_e,
    input  logic [XLEN-1:0]  target_e,
    input  logic [XLEN-1:0]  pc_plus4_e,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             taken_e,
    output logic             update_en,
    output logic             flush_d,
    output logic             flush_e,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    logic            d_v;
    logic            d_pt;
    logic [XLEN-1:0] d_ptgt;
    logic            e_v;
    logic            e_pt;
    logic [XLEN-1:0] e_ptgt;

    brs_state_e state;
    brs_state_e state_next;
    cf_class_e  cf;
    logic       ctl_e;
    logic       wrong;
    logic       br_inc;

    // Prediction tracking, one stage per cycle alongside the instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_v    <= 1'b0;
            d_pt   <= 1'b0;
            d_ptgt <= '0;
            e_v    <= 1'b0;
            e_pt   <= 1'b0;
            e_ptgt <= '0;
        end else begin
            if (flush_d) begin
                d_v <= 1'b0;
            end else if (!stall_d) begin
                d_v    <= valid_f;
                d_pt   <= pred_taken_f;
                d_ptgt <= pred_target_f;
            end
            // A stall sends a bubble into E; a flush kills the E-bound slot.
            if (flush_e || stall_d) begin
                e_v <= 1'b0;
            end else begin
                e_v    <= d_v;
                e_pt   <= d_pt;
                e_ptgt <= d_ptgt;
            end
        end
    end

    // Recovery FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Recovery FSM next state: one masked cycle after every redirect.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:     if (wrong) state_next = ST_RECOVER;
            ST_RECOVER: state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
    end

    // Resolution and masked outputs.
    always_comb begin
        cf          = cf_class(is_branch_e, is_jal_e, is_jalr_e);
        ctl_e       = e_v && (cf != CF_NONE);
        taken_e     = ctl_e && ((cf == CF_JAL) || (cf == CF_JALR) ||
                                ((cf == CF_BRANCH) && cond_true_e));
        // Covers wrong direction, wrong target, and taken-predicted non-control.
        wrong       = e_v && ((taken_e != e_pt) ||
                              (taken_e && (e_ptgt != target_e)));
        redirect_pc = taken_e ? target_e : pc_plus4_e;
        mispredict  = 1'b0;
        update_en   = 1'b0;
        br_inc      = 1'b0;
        if (state == ST_RUN) begin
            mispredict = wrong;
            update_en  = e_v && (cf == CF_BRANCH);
            br_inc     = ctl_e;
        end
        flush_d = mispredict;
        flush_e = mispredict;
    end

    sat_counter #(.W(CNT_W)) u_br_count (
        .clk   (clk),
        .reset (reset),
        .inc   (br_inc),
        .clear (1'b0),
        .count (br_count)
    );

    sat_counter #(.W(CNT_W)) u_mp_count (
        .clk   (clk),
        .reset (reset),
        .inc   (mispredict),
        .clear (1'b0),
        .count (mp_count)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus
// randomized traffic compared against a behavioural pipeline model.
module tb_branch_resolve_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic            v;
        logic            pt;
        logic [XLEN-1:0] tgt;
    } rec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall_d, pred_taken_f, valid_f;
    logic [XLEN-1:0]  pred_target_f;
    logic             is_branch_e, is_jal_e, is_jalr_e, cond_true_e;
    logic [XLEN-1:0]  target_e, pc_plus4_e;
    logic             mispredict, taken_e, update_en, flush_d, flush_e;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] br_count, mp_count;

    int checks = 0;
    int errors = 0;

    // Model state
    rec_t             md, me;
    logic             m_recover;
    logic [CNT_W-1:0] m_br, m_mp;
    logic             exp_mp, exp_ctl;
    logic [CNT_W-1:0] base;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall_d(stall_d),
        .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f), .valid_f(valid_f),
        .is_branch_e(is_branch_e), .is_jal_e(is_jal_e), .is_jalr_e(is_jalr_e),
        .cond_true_e(cond_true_e), .target_e(target_e), .pc_plus4_e(pc_plus4_e),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .taken_e(taken_e),
        .update_en(update_en), .flush_d(flush_d), .flush_e(flush_e),
        .br_count(br_count), .mp_count(mp_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        md = '0; me = '0; m_recover = 1'b0; m_br = '0; m_mp = '0;
    endtask

    task automatic clear_e();
        is_branch_e = 1'b0; is_jal_e = 1'b0; is_jalr_e = 1'b0; cond_true_e = 1'b0;
    endtask

    // Sample combinational and counter outputs away from the edge and compare with the model.
    task automatic settle();
        logic taken, wrong, upd;
        logic [XLEN-1:0] redir;
        @(negedge clk);
        exp_ctl = me.v && (is_branch_e || is_jal_e || is_jalr_e);
        taken   = exp_ctl && (is_jal_e || is_jalr_e || (is_branch_e && cond_true_e));
        // Prediction is right only if direction matches and, when taken, so does the target.
        wrong   = me.v && ((me.pt != taken) || (taken && (me.tgt != target_e)));
        exp_mp  = wrong && !m_recover;
        upd     = me.v && is_branch_e && !m_recover;
        redir   = taken ? target_e : pc_plus4_e;
        check("mispredict", 64'(mispredict), 64'(exp_mp));
        check("flush_d", 64'(flush_d), 64'(exp_mp));
        check("flush_e", 64'(flush_e), 64'(exp_mp));
        check("taken_e", 64'(taken_e), 64'(taken));
        check("update_en", 64'(update_en), 64'(upd));
        check("redirect_pc", 64'(redirect_pc), 64'(redir));
        check("br_count", 64'(br_count), 64'(m_br));
        check("mp_count", 64'(mp_count), 64'(m_mp));
    endtask

    // Clock edge: advance the model with the inputs the DUT sampled.
    task automatic advance();
        rec_t new_e;
        @(posedge clk);
        if (!m_recover) begin
            if (exp_ctl && m_br != CMAX) m_br = m_br + 1'b1;
            if (exp_mp && m_mp != CMAX) m_mp = m_mp + 1'b1;
        end
        new_e = (exp_mp || stall_d) ? '0 : md;
        if (exp_mp) md.v = 1'b0;
        else if (!stall_d) md = '{v: valid_f, pt: pred_taken_f, tgt: pred_target_f};
        me = new_e;
        m_recover = exp_mp;
        #1;
    endtask

    // Drain the pipe, then put one predicted instruction into E.
    task automatic load_pred(input logic pt, input logic [XLEN-1:0] tgt);
        clear_e(); stall_d = 1'b0; valid_f = 1'b0; pred_taken_f = 1'b0;
        repeat (2) begin settle(); advance(); end
        valid_f = 1'b1; pred_taken_f = pt; pred_target_f = tgt;
        settle(); advance();
        valid_f = 1'b0; pred_taken_f = 1'b0;
        settle(); advance();
    endtask

    task automatic random_inputs();
        int k;
        stall_d       = ($urandom_range(0, 3) == 0);
        valid_f       = ($urandom_range(0, 4) != 0);
        pred_taken_f  = 1'($urandom_range(0, 1));
        pred_target_f = 32'h100 + 32'($urandom_range(0, 3)) * 4;
        k = int'($urandom_range(0, 3));
        is_branch_e   = (k == 1);
        is_jal_e      = (k == 2);
        is_jalr_e     = (k == 3);
        cond_true_e   = 1'($urandom_range(0, 1));
        target_e      = 32'h100 + 32'($urandom_range(0, 3)) * 4;
        pc_plus4_e    = 32'h200 + 32'($urandom_range(0, 15)) * 4;
    endtask

    initial begin
        reset = 1'b1;
        stall_d = 1'b0; valid_f = 1'b1; pred_taken_f = 1'b1; pred_target_f = 32'h40;
        clear_e(); is_jal_e = 1'b1; target_e = 32'h44; pc_plus4_e = 32'h8;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mispredict", 64'(mispredict), 64'd0);
        check("rst_taken_e", 64'(taken_e), 64'd0);
        check("rst_update_en", 64'(update_en), 64'd0);
        check("rst_flush", 64'({flush_d, flush_e}), 64'd0);
        check("rst_counts", 64'({br_count, mp_count}), 64'd0);
        reset = 1'b0;

        // BEQ predicted taken to 0x140, falls through.
        load_pred(1'b1, 32'h140);
        is_branch_e = 1'b1; cond_true_e = 1'b0; target_e = 32'h140; pc_plus4_e = 32'h104;
        settle();
        check("beq_mp", 64'(mispredict), 64'd1);
        check("beq_redirect", 64'(redirect_pc), 64'h104);
        check("beq_flush", 64'({flush_d, flush_e}), 64'b11);
        check("beq_update", 64'(update_en), 64'd1);
        advance();
        check("beq_mp_count", 64'(mp_count), 64'd1);
        check("beq_br_count", 64'(br_count), 64'd1);

        // BNE predicted not taken, actually taken to 0x80.
        load_pred(1'b0, 32'h0);
        is_branch_e = 1'b1; cond_true_e = 1'b1; target_e = 32'h80; pc_plus4_e = 32'h204;
        settle();
        check("bne_mp", 64'(mispredict), 64'd1);
        check("bne_redirect", 64'(redirect_pc), 64'h80);
        check("bne_taken", 64'(taken_e), 64'd1);
        advance();

        // JALR with wrong predicted target.
        load_pred(1'b1, 32'h200);
        is_jalr_e = 1'b1; target_e = 32'h204; pc_plus4_e = 32'h30;
        settle();
        check("jalr_mp", 64'(mispredict), 64'd1);
        check("jalr_redirect", 64'(redirect_pc), 64'h204);
        check("jalr_update", 64'(update_en), 64'd0);
        advance();

        // Correctly predicted taken BEQ while stall_d is high.
        load_pred(1'b1, 32'h300);
        base = m_br;
        is_branch_e = 1'b1; cond_true_e = 1'b1; target_e = 32'h300; pc_plus4_e = 32'h54;
        stall_d = 1'b1;
        settle();
        check("stall_mp", 64'(mispredict), 64'd0);
        check("stall_taken", 64'(taken_e), 64'd1);
        advance();
        clear_e(); is_jal_e = 1'b1; target_e = 32'h600;
        settle();
        check("stall_bubble_taken", 64'(taken_e), 64'd0);
        check("stall_br_once", 64'(br_count), 64'(base + 1'b1));
        advance();
        stall_d = 1'b0; clear_e();
        settle();
        check("stall_br_once_2", 64'(br_count), 64'(base + 1'b1));
        advance();

        // Mispredict followed by a squashed branch in the recovery cycle.
        load_pred(1'b0, 32'h0);
        is_jal_e = 1'b1; target_e = 32'h500; pc_plus4_e = 32'h70;
        settle();
        check("rec_mp", 64'(mispredict), 64'd1);
        advance();
        base = m_br;
        clear_e(); is_branch_e = 1'b1; cond_true_e = 1'b1; target_e = 32'h500;
        settle();
        check("rec_squash_mp", 64'(mispredict), 64'd0);
        check("rec_squash_update", 64'(update_en), 64'd0);
        advance();
        clear_e();
        settle();
        check("rec_counts", 64'(br_count), 64'(base));
        advance();

        // Random traffic, long enough to saturate br_count.
        repeat (1500) begin
            random_inputs();
            settle();
            advance();
        end
        check("br_saturated", 64'(br_count), 64'(CMAX));

        // Reset in the middle of a redirect: outputs drop without waiting for a clock.
        load_pred(1'b1, 32'h100);
        pc_plus4_e = 32'h88;
        settle();
        check("pre_reset_mp", 64'(mispredict), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_mp", 64'(mispredict), 64'd0);
        check("async_rst_flush", 64'({flush_d, flush_e}), 64'd0);
        check("async_rst_counts", 64'({br_count, mp_count}), 64'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;

        repeat (300) begin
            random_inputs();
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
